// File: rtl/pll_clken_pkg.sv
// Shared types and defaults for the post-PLL clock controller.
//   pll_state_t : lock/reset sequencing states
//   *_DEF       : default channel count and widths
package pll_clken_pkg;

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN, HOLD} pll_state_t;

  localparam int NCH_DEF    = 4;
  localparam int DIV_W_DEF  = 16;
  localparam int LOSS_W_DEF = 8;

endpackage

// File: rtl/clken_div_chan.sv
// One clock-enable channel: shadow divisor, active divisor, counter, strobe.
//   clock_in : PLL output clock
//   reset_n  : synchronous active-low reset
//   run      : controller is in RUN; counter is held at zero otherwise
//   wr       : load wr_val into the shadow divisor
//   wr_val   : new divisor
//   ce       : one-cycle enable strobe, high on the last count of a period
module clken_div_chan #(
  parameter int               DIV_W    = 16,
  parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(4)
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  output logic             ce
);

  logic [DIV_W-1:0] shadow, act, cnt;
  logic             wrap;

  // Divisors 0 and 1 both mean "every cycle"; the short-circuit also keeps
  // act-1 from underflowing when act is 0.
  assign wrap = (act <= DIV_W'(1)) || (cnt == act - DIV_W'(1));
  assign ce   = run && wrap;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      shadow <= DIV_INIT;
      act    <= DIV_INIT;
      cnt    <= '0;
    end else begin
      if (wr) shadow <= wr_val;
      // The active divisor only changes on a period boundary, so a write that
      // lands on the wrap cycle is picked up at the wrap after this one.
      if (!run || wrap) begin
        cnt <= '0;
        act <= shadow;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pll_clken_ctrl.sv
// Post-PLL clock controller. Qualifies PLL lock, sequences the core reset,
// produces NCH phase-aligned clock-enable strobes and counts lock losses.
//   clock_in    : PLL output clock (only clock)
//   reset_n     : synchronous active-low reset
//   locked      : raw PLL lock, asynchronous to clock_in
//   div_wr      : divisor write strobe
//   div_sel     : channel index for the write (out-of-range ignored)
//   div_val     : new divisor
//   lost_clr    : clears lost_sticky
//   sys_reset_n : registered core reset, active-low
//   ce          : per-channel one-cycle enable strobes
//   lost_sticky : set on a lock loss while running
//   lost_cnt    : saturating lock-loss count
module pll_clken_ctrl
  import pll_clken_pkg::*;
#(
  parameter int                          NCH         = NCH_DEF,
  parameter int                          DIV_W       = DIV_W_DEF,
  parameter logic [NCH-1:0][DIV_W-1:0]   DIV_INIT    = {DIV_W'(50), DIV_W'(16), DIV_W'(8), DIV_W'(4)},
  parameter int                          LOCK_STABLE = 1024,
  parameter int                          RST_HOLD    = 16,
  parameter int                          LOSS_W      = LOSS_W_DEF,
  parameter int                          SEL_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              locked,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              lost_clr,
  output logic              sys_reset_n,
  output logic [NCH-1:0]    ce,
  output logic              lost_sticky,
  output logic [LOSS_W-1:0] lost_cnt
);

  // One counter serves both the stability window and the reset hold.
  localparam int CNT_MAX = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

  pll_state_t       state;
  logic [1:0]       sync;
  logic             locked_s;
  logic [CNT_W-1:0] tcnt;
  logic             run;

  assign locked_s = sync[1];
  assign run      = (state == RUN);

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      sync        <= '0;
      state       <= WAIT_LOCK;
      tcnt        <= '0;
      sys_reset_n <= 1'b0;
      lost_sticky <= 1'b0;
      lost_cnt    <= '0;
    end else begin
      sync <= {sync[0], locked};
      // Placed before the FSM so a loss on the same edge overrides the clear.
      if (lost_clr) lost_sticky <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          tcnt <= '0;
          if (locked_s) state <= STABLE;
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            tcnt  <= '0;
          end else if (tcnt == STAB_LAST) begin
            state       <= RUN;
            sys_reset_n <= 1'b1;
            tcnt        <= '0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state       <= HOLD;
            sys_reset_n <= 1'b0;
            tcnt        <= '0;
            lost_sticky <= 1'b1;
            if (lost_cnt != '1) lost_cnt <= lost_cnt + LOSS_W'(1);
          end
        end
        HOLD: begin
          // Exit does not look at lock; WAIT_LOCK re-qualifies it.
          if (tcnt == HOLD_LAST) begin
            state <= WAIT_LOCK;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= WAIT_LOCK;
          sys_reset_n <= 1'b0;
          tcnt        <= '0;
        end
      endcase
    end
  end

  // Every channel counter sits at zero until RUN, so all strobes are
  // phase-aligned to the first RUN cycle.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic wr_g;
    assign wr_g = div_wr && (32'(div_sel) == g);

    clken_div_chan #(
      .DIV_W   (DIV_W),
      .DIV_INIT(DIV_INIT[g])
    ) u_chan (
      .clock_in(clock_in),
      .reset_n (reset_n),
      .run     (run),
      .wr      (wr_g),
      .wr_val  (div_val),
      .ce      (ce[g])
    );
  end

endmodule

// File: tb/tb_pll_clken_ctrl.sv
module tb_pll_clken_ctrl;
  localparam int NCH = 4, DIV_W = 16, LS = 1024, RH = 16, LOSS_W = 8;
  localparam int S_LS = 4, S_RH = 2;

  logic clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  logic              reset_n, locked, div_wr, lost_clr;
  logic [1:0]        div_sel;
  logic [DIV_W-1:0]  div_val;
  logic              sys_reset_n, lost_sticky;
  logic [NCH-1:0]    ce;
  logic [LOSS_W-1:0] lost_cnt;

  // Second, small instance: short lock window for the saturation run, and
  // NCH=3 so that div_sel=3 is a real out-of-range index.
  logic              locked2, div_wr2;
  logic [1:0]        div_sel2;
  logic [DIV_W-1:0]  div_val2;
  logic              sys_reset_n2, lost_sticky2;
  logic [2:0]        ce2;
  logic [LOSS_W-1:0] lost_cnt2;

  pll_clken_ctrl #(
    .NCH(NCH), .DIV_W(DIV_W), .LOCK_STABLE(LS), .RST_HOLD(RH), .LOSS_W(LOSS_W)
  ) u_dut (
    .clock_in(clock_in), .reset_n(reset_n), .locked(locked),
    .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val), .lost_clr(lost_clr),
    .sys_reset_n(sys_reset_n), .ce(ce), .lost_sticky(lost_sticky), .lost_cnt(lost_cnt)
  );

  pll_clken_ctrl #(
    .NCH(3), .DIV_W(DIV_W), .DIV_INIT({16'd16, 16'd8, 16'd4}),
    .LOCK_STABLE(S_LS), .RST_HOLD(S_RH), .LOSS_W(LOSS_W)
  ) u_small (
    .clock_in(clock_in), .reset_n(reset_n), .locked(locked2),
    .div_wr(div_wr2), .div_sel(div_sel2), .div_val(div_val2), .lost_clr(1'b0),
    .sys_reset_n(sys_reset_n2), .ce(ce2), .lost_sticky(lost_sticky2), .lost_cnt(lost_cnt2)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: phase plus cycles-in-phase, and per channel the RUN
  // cycle number of the next strobe.
  int ph;          // 0 wait, 1 stable, 2 run, 3 hold
  int t, h, k;     // cycles spent in STABLE / HOLD / RUN (1-based)
  bit s1, s2;
  bit m_sticky;
  int m_lost;
  int sh_m[NCH], act_m[NCH], nxt[NCH];
  int init_div[NCH] = '{4, 8, 16, 50};

  function automatic int max1(input int a);
    return (a < 1) ? 1 : a;
  endfunction

  task automatic model_edge();
    bit ls;
    bit loss;
    int old_ph, old_k;
    ls = s2; loss = 0; old_ph = ph; old_k = k;
    if (!reset_n) begin
      ph = 0; t = 0; h = 0; k = 0; s1 = 0; s2 = 0; m_sticky = 0; m_lost = 0;
      for (int i = 0; i < NCH; i++) begin
        sh_m[i] = init_div[i]; act_m[i] = init_div[i]; nxt[i] = 0;
      end
      return;
    end
    s2 = s1; s1 = locked;
    case (old_ph)
      0: if (ls) begin ph = 1; t = 1; end
      1: if (!ls) ph = 0; else if (t == LS) begin ph = 2; k = 1; end else t++;
      2: if (!ls) begin ph = 3; h = 1; loss = 1; end else k++;
      default: if (h == RH) ph = 0; else h++;
    endcase
    if (loss) begin
      m_sticky = 1;
      if (m_lost < 255) m_lost++;
    end else if (lost_clr) m_sticky = 0;
    for (int i = 0; i < NCH; i++) begin
      if (old_ph != 2) act_m[i] = sh_m[i];
      else if (old_k == nxt[i]) begin
        act_m[i] = sh_m[i];
        nxt[i] = old_k + max1(act_m[i]);
      end
      if (ph == 2 && old_ph != 2) nxt[i] = max1(act_m[i]);
      if (div_wr && div_sel == i) sh_m[i] = div_val;
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] e;
    for (int i = 0; i < NCH; i++) e[i] = (ph == 2 && k == nxt[i]);
    chk("sys_reset_n", sys_reset_n, ph == 2);
    chk("ce", ce, e);
    chk("lost_sticky", lost_sticky, m_sticky);
    chk("lost_cnt", lost_cnt, m_lost);
  endtask

  task automatic tick();
    @(posedge clock_in);
    model_edge();
    @(negedge clock_in);
    check_all();
  endtask

  task automatic wait_ce(input int ch, output int n);
    n = 0;
    do begin tick(); n++; end while (!ce[ch] && n < 200);
    if (!ce[ch]) n = -1;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (sys_reset_n !== 1'b1 && n < 3000) begin tick(); n++; end
    if (sys_reset_n !== 1'b1) n = -1;
  endtask

  task automatic wr(input int ch, input int v);
    div_wr = 1'b1; div_sel = 2'(ch); div_val = DIV_W'(v);
  endtask

  initial begin
    int n, cnt;
    reset_n = 0; locked = 1; div_wr = 0; div_sel = 0; div_val = 0; lost_clr = 0;
    locked2 = 0; div_wr2 = 0; div_sel2 = 2'd3; div_val2 = 0;
    repeat (3) tick();
    chk("rst_sys_reset_n", sys_reset_n, 0);
    chk("rst_ce", ce, 0);
    chk("rst_lost_sticky", lost_sticky, 0);
    chk("rst_lost_cnt", lost_cnt, 0);
    reset_n = 1;

    // Lock held from release: rise after sync(2) + window + registered output
    wait_run(n);
    chk("lock_to_run_cycles", n, LS + 3);
    wait_ce(0, n);
    chk("first_ce0_run_cycle", n + 1, 4);

    // ch1 divisor changes take effect on period boundaries
    wait_ce(1, n); chk("ce1_first", n, 4);
    tick();
    wr(1, 3); tick(); div_wr = 0;
    wait_ce(1, n); chk("ch1_old_period_rest", n, 6);
    wait_ce(1, n); chk("ch1_new_period_a", n, 3);
    wait_ce(1, n); chk("ch1_new_period_b", n, 3);
    tick();
    wr(1, 8); tick(); div_wr = 0;
    wait_ce(1, n); chk("ch1_tail3", n, 1);
    wait_ce(1, n); chk("ch1_back8", n, 8);
    wr(1, 3); tick(); div_wr = 0;
    wait_ce(1, n); chk("ch1_wrap_write_extra8", n + 1, 8);
    wait_ce(1, n); chk("ch1_after_wrap_write", n, 3);

    // ch2 divisor 0 and 1 both strobe every RUN cycle
    wr(2, 0); tick(); div_wr = 0;
    wait_ce(2, n);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (ce[2]) cnt++; end
    chk("ch2_div0_const", cnt, 10);
    wr(2, 1); tick(); div_wr = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (ce[2]) cnt++; end
    chk("ch2_div1_const", cnt, 10);
    wr(2, 16); tick(); div_wr = 0;

    // One-cycle lock drop in RUN
    locked = 0; tick(); locked = 1;
    n = 1;
    while (sys_reset_n !== 1'b0 && n < 10) begin tick(); n++; end
    chk("loss_to_hold_cycles", n, 3);
    cnt = 0;
    for (int i = 1; i < RH; i++) begin tick(); if (sys_reset_n === 1'b0) cnt++; end
    chk("hold_low_len", cnt, RH - 1);
    chk("loss_cnt_1", lost_cnt, 1);
    chk("loss_sticky_1", lost_sticky, 1);
    lost_clr = 1; tick(); lost_clr = 0;
    chk("sticky_cleared", lost_sticky, 0);
    chk("lost_cnt_kept", lost_cnt, 1);

    // Drop deep inside STABLE: full window restarts after relock
    repeat (500) tick();
    locked = 0; repeat (3) tick(); locked = 1;
    wait_run(n);
    chk("relock_full_count", n, LS + 3);

    // Loss and clear on the same edge: loss wins
    locked = 0; tick(); locked = 1; tick();
    lost_clr = 1; tick(); lost_clr = 0;
    chk("loss_beats_clr", lost_sticky, 1);
    chk("loss_cnt_2", lost_cnt, 2);

    // Randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < 6000; c++) begin
      div_wr   = ($urandom % 6 == 0);
      div_sel  = 2'($urandom % 4);
      div_val  = DIV_W'($urandom % 13);
      lost_clr = ($urandom % 40 == 0);
      locked   = ($urandom % 1500 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    div_wr = 0; lost_clr = 0; locked = 1;

    // Reset pulse in RUN
    wait_run(n);
    chk("run_before_reset", n >= 0, 1);
    reset_n = 0; tick(); reset_n = 1;
    chk("midrun_rst_sys_reset_n", sys_reset_n, 0);
    chk("midrun_rst_ce", ce, 0);
    chk("midrun_rst_sticky", lost_sticky, 0);
    chk("midrun_rst_cnt", lost_cnt, 0);

    // Small instance: out-of-range writes ignored, loss counter saturates
    for (int l = 1; l <= 260; l++) begin
      locked2 = 1;
      repeat (S_LS + 2) tick();
      chk("small_pre_run", sys_reset_n2, 0);
      tick();
      chk("small_run_rise", sys_reset_n2, 1);
      if (l == 1) begin
        div_wr2 = 1; div_sel2 = 2'd3; div_val2 = 16'd1;
        for (int kk = 1; kk <= 40; kk++) begin
          chk("small_oob_ce", ce2, {3'(kk % 16 == 0), 3'(kk % 8 == 0), 3'(kk % 4 == 0)} & 3'b111 ?
              {kk % 16 == 0, kk % 8 == 0, kk % 4 == 0} : 3'b000);
          tick();
        end
        div_wr2 = 0;
      end
      locked2 = 0;
      repeat (6) tick();
      chk("small_lost_cnt", lost_cnt2, (l < 255) ? l : 255);
      if (l == 1) chk("small_sticky", lost_sticky2, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
